// File: rtl/charge_run_arbiter.sv
// Two-requester round-robin arbiter in front of a charge-control loop.
// Owns settle delay, run timeout, abort handling and result capture.
module charge_run_arbiter #(
  parameter int BUS_WIDTH      = 10,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_a,
  input  logic                 req_b,
  input  logic [BUS_WIDTH-1:0] q_des_a,
  input  logic [BUS_WIDTH-1:0] q_des_b,
  output logic                 gnt_a,
  output logic                 gnt_b,
  output logic                 loop_enable,
  output logic                 loop_start,
  output logic [BUS_WIDTH-1:0] loop_q_desired,
  input  logic                 loop_done,
  input  logic [BUS_WIDTH-1:0] q_meas,
  output logic                 result_valid,
  output logic                 result_id,
  output logic                 result_timeout,
  output logic [BUS_WIDTH-1:0] q_result
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RUN,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic                 cur_q, cur_d;
  logic [BUS_WIDTH-1:0] qdes_q, qdes_d;
  logic [BUS_WIDTH-1:0] qres_q, qres_d;
  logic                 rid_q, rid_d;
  logic                 rto_q, rto_d;
  logic                 own_req;
  logic                 win;
  logic                 active;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    cur_d   = cur_q;
    qdes_d  = qdes_q;
    qres_d  = qres_q;
    rid_d   = rid_q;
    rto_d   = rto_q;
    own_req = cur_q ? req_b : req_a;
    // Tie goes to whoever did not own the loop last
    win     = (req_a && req_b) ? ~last_q : req_b;
    unique case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          state_d = SETTLE;
          cur_d   = win;
          qdes_d  = win ? q_des_b : q_des_a;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (!own_req) begin
          state_d = IDLE;
          last_d  = cur_q;
          cnt_d   = '0;
        end else if (qdes_q == '0) begin
          state_d = DONE;
          qres_d  = '0;
          rto_d   = 1'b0;
          rid_d   = cur_q;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: begin
        if (!own_req) begin
          state_d = IDLE;
          last_d  = cur_q;
          cnt_d   = '0;
        end else if (loop_done) begin
          state_d = DONE;
          qres_d  = q_meas;
          rto_d   = 1'b0;
          rid_d   = cur_q;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = DONE;
          qres_d  = q_meas;
          rto_d   = 1'b1;
          rid_d   = cur_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = cur_q;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      cur_q   <= 1'b0;
      qdes_q  <= '0;
      qres_q  <= '0;
      rid_q   <= 1'b0;
      rto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      cur_q   <= cur_d;
      qdes_q  <= qdes_d;
      qres_q  <= qres_d;
      rid_q   <= rid_d;
      rto_q   <= rto_d;
    end
  end

  assign active         = (state_q == SETTLE) || (state_q == RUN);
  assign gnt_a          = active && !cur_q;
  assign gnt_b          = active && cur_q;
  assign loop_enable    = active;
  assign loop_start     = (state_q == RUN);
  assign loop_q_desired = qdes_q;
  assign result_valid   = (state_q == DONE);
  assign result_id      = rid_q;
  assign result_timeout = rto_q;
  assign q_result       = qres_q;

endmodule

// File: tb/tb_charge_run_arbiter.sv
// Scoreboard bench for charge_run_arbiter: directed runs, fairness,
// timeout, abort, zero-charge and mid-run reset.
module tb_charge_run_arbiter;
  localparam int BW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_a = 1'b0, req_b = 1'b0, loop_done = 1'b0;
  logic [BW-1:0] q_des_a = '0, q_des_b = '0, q_meas = '0;
  logic          gnt_a, gnt_b, loop_enable, loop_start;
  logic          result_valid, result_id, result_timeout;
  logic [BW-1:0] loop_q_desired, q_result;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic          id;
    logic          to;
    logic [BW-1:0] q;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  charge_run_arbiter #(
    .BUS_WIDTH(BW),
    .SETTLE_CYCLES(4),
    .TIMEOUT_CYCLES(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_a(req_a),
    .req_b(req_b),
    .q_des_a(q_des_a),
    .q_des_b(q_des_b),
    .gnt_a(gnt_a),
    .gnt_b(gnt_b),
    .loop_enable(loop_enable),
    .loop_start(loop_start),
    .loop_q_desired(loop_q_desired),
    .loop_done(loop_done),
    .q_meas(q_meas),
    .result_valid(result_valid),
    .result_id(result_id),
    .result_timeout(result_timeout),
    .q_result(q_result)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic id, input logic to, input logic [BW-1:0] q);
    exp_t e;
    e.id = id;
    e.to = to;
    e.q  = q;
    sb.push_back(e);
  endtask

  // Monitor: pops one expectation per result pulse
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      chk("gnt_onehot", {31'd0, gnt_a & gnt_b}, 0);
      if (result_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_result actual=valid expected=none q=%0d",
                   q_result);
        end else begin
          e = sb.pop_front();
          chk("res_id", result_id, e.id);
          chk("res_timeout", result_timeout, e.to);
          chk("res_q", q_result, e.q);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #12;
    chk("rst_gnt_a", gnt_a, 0);
    chk("rst_gnt_b", gnt_b, 0);
    chk("rst_en", loop_enable, 0);
    chk("rst_start", loop_start, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_id", result_id, 0);
    chk("rst_to", result_timeout, 0);
    chk("rst_qdes", loop_q_desired, 0);
    chk("rst_qres", q_result, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    tick();

    // Single run on A
    req_a = 1'b1;
    q_des_a = 10'd210;
    tick();
    chk("a_gnt", gnt_a, 1);
    chk("a_gnt_b", gnt_b, 0);
    chk("a_en", loop_enable, 1);
    chk("a_qdes", loop_q_desired, 210);
    q_des_a = 10'd5;
    tick(3);
    chk("a_settle", loop_start, 0);
    tick();
    chk("a_start", loop_start, 1);
    chk("a_qdes_hold", loop_q_desired, 210);
    tick(21);
    loop_done = 1'b1;
    q_meas = 10'd212;
    push(1'b0, 1'b0, 10'd212);
    tick();
    loop_done = 1'b0;
    req_a = 1'b0;
    chk("a_valid", result_valid, 1);
    chk("a_start_off", loop_start, 0);
    chk("a_en_off", loop_enable, 0);
    chk("a_gnt_off", gnt_a, 0);
    tick();
    chk("a_pulse", result_valid, 0);
    chk("a_hold_q", q_result, 212);
    chk("a_hold_id", result_id, 0);
    loop_done = 1'b1;
    tick();
    loop_done = 1'b0;
    tick(2);
    chk("stray_done", result_valid, 0);

    // Timeout on B
    req_b = 1'b1;
    q_des_b = 10'd300;
    q_meas = 10'd287;
    tick();
    chk("b_gnt", gnt_b, 1);
    chk("b_gnt_a", gnt_a, 0);
    chk("b_qdes", loop_q_desired, 300);
    tick(4);
    chk("b_start", loop_start, 1);
    push(1'b1, 1'b1, 10'd287);
    n = 0;
    while (n < 400 && result_valid !== 1'b1) begin
      tick();
      n++;
    end
    chk("b_timeout_lat", n, 255);
    req_b = 1'b0;
    tick(2);

    // Abort A in RUN with B pending
    req_a = 1'b1;
    q_des_a = 10'd100;
    tick();
    chk("ab_gnt_a", gnt_a, 1);
    req_b = 1'b1;
    q_des_b = 10'd150;
    tick(4);
    chk("ab_start", loop_start, 1);
    tick(3);
    req_a = 1'b0;
    tick();
    chk("ab_start_off", loop_start, 0);
    chk("ab_en_off", loop_enable, 0);
    chk("ab_gnt_a_off", gnt_a, 0);
    chk("ab_idle_gnt_b", gnt_b, 0);
    chk("ab_no_result", result_valid, 0);
    tick();
    chk("ab_gnt_b", gnt_b, 1);
    chk("ab_qdes_b", loop_q_desired, 150);
    tick(4);
    chk("ab_b_start", loop_start, 1);
    q_meas = 10'd77;
    loop_done = 1'b1;
    push(1'b1, 1'b0, 10'd77);
    tick();
    loop_done = 1'b0;
    req_b = 1'b0;
    chk("ab_b_valid", result_valid, 1);
    tick(2);

    // Zero desired charge skips the loop
    req_a = 1'b1;
    q_des_a = 10'd0;
    q_meas = 10'd99;
    push(1'b0, 1'b0, 10'd0);
    tick();
    chk("z_gnt", gnt_a, 1);
    chk("z_start0", loop_start, 0);
    tick();
    chk("z_valid", result_valid, 1);
    chk("z_start1", loop_start, 0);
    chk("z_gnt_off", gnt_a, 0);
    req_a = 1'b0;
    tick(2);

    // Fairness from reset with both requesting
    rst = 1'b0;
    req_a = 1'b1;
    req_b = 1'b1;
    q_des_a = 10'd50;
    q_des_b = 10'd60;
    tick();
    rst = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 8 && !(gnt_a || gnt_b); k++) tick();
      chk("f_gnt_a", gnt_a, (r % 2 == 0));
      chk("f_gnt_b", gnt_b, (r % 2 == 1));
      chk("f_qdes", loop_q_desired, (r % 2 == 1) ? 60 : 50);
      for (int k = 0; k < 8 && !loop_start; k++) tick();
      chk("f_start", loop_start, 1);
      tick(4);
      q_meas = BW'(100 + r);
      loop_done = 1'b1;
      push(r[0], 1'b0, BW'(100 + r));
      tick();
      loop_done = 1'b0;
      chk("f_valid", result_valid, 1);
    end

    // Reset in the middle of a run
    req_b = 1'b0;
    for (int k = 0; k < 12 && !loop_start; k++) tick();
    chk("mr_start", loop_start, 1);
    tick(2);
    #1 rst = 1'b0;
    #1;
    chk("mr_start_off", loop_start, 0);
    chk("mr_en_off", loop_enable, 0);
    chk("mr_gnt_off", gnt_a, 0);
    chk("mr_qdes", loop_q_desired, 0);
    chk("mr_qres", q_result, 0);
    chk("mr_valid", result_valid, 0);
    #1 rst = 1'b1;
    #1;
    chk("mr_no_early_gnt", gnt_a, 0);
    tick();
    chk("mr_gnt_after", gnt_a, 1);
    req_a = 1'b0;
    tick(3);
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
